vga_scaled_fb_reader: RTL

- Parametrised successor to the fixed 640x480 VGA controller.
- Generates configurable VGA timing, reads a down-scaled framebuffer through a dual-port RAM read port with configurable read latency, and expands N-bit grey pixels to RGB332.
- Adds frame-synchronous mode switching among framebuffer, colour bars, checkerboard and solid colour, plus a frame-start strobe for capture and framebuffer handshaking.
- Sits between the framebuffer read port and the VGA pins, in the VGA clock domain.

---
 rtl/vga_scaled_fb_reader_if.sv | 13 +
 rtl/vga_scaled_fb_reader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaled_fb_reader_if.sv
// Framebuffer read-port bundle between vga_scaled_fb_reader and a dual-port RAM.
//   addr : read address driven by the reader (master)
//   din  : read data returned by the RAM (slave) a fixed number of clocks later
interface vga_scaled_fb_reader_if #(
  parameter int ADDR_W = 17,
  parameter int DIN_W  = 2
);
  logic [ADDR_W-1:0] addr;
  logic [DIN_W-1:0]  din;

  modport master (output addr, input din);
  modport slave  (input addr, output din);
endinterface

// File: rtl/vga_scaled_fb_reader.sv
// VGA timing generator and down-scaled framebuffer reader.
// Produces configurable VGA timing, fetches SCALE x SCALE replicated pixels from
// a framebuffer RAM with RAM_LAT read latency, expands grey pixels to RGB332 and
// offers colour-bar, checkerboard and solid test patterns chosen once per frame.
// Ports:
//   clk, reset_n          pixel clock, asynchronous active-low reset
//   mode, solid_rgb       pattern select / solid colour, sampled at pixel (0,0)
//   fb (master)           framebuffer read port: addr out, din in
//   hsync, vsync          syncs, asserted level = SYNC_POL
//   R, G, B               RGB332 pixel, zero during blanking
//   active, frame_start   visible-pixel flag, one-cycle pulse at pixel (0,0)
// All outputs lag the timing counters by RAM_LAT+1 clocks.
module vga_scaled_fb_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SCALE    = 2,
  parameter int DIN_W    = 2,
  parameter int ADDR_W   = 17,
  parameter int RAM_LAT  = 1,
  parameter int SYNC_POL = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             mode,
  input  logic [7:0]             solid_rgb,
  vga_scaled_fb_reader_if.master fb,
  output logic                   hsync,
  output logic                   vsync,
  output logic [2:0]             R,
  output logic [2:0]             G,
  output logic [1:0]             B,
  output logic                   active,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);
  localparam int XS_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam logic SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF = (SYNC_POL != 0) ? 1'b0 : 1'b1;
  localparam logic [XS_W-1:0]   XS_LAST = XS_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] FB_STEP = ADDR_W'(H_ACTIVE / SCALE);

  // Everything that must stay aligned with the RAM data while it is fetched.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vis;
    logic       fs;
    logic       use_fb;
    logic [7:0] pat;
  } stage_t;

  localparam stage_t STAGE_RST = '{hs: SYNC_OFF, vs: SYNC_OFF, vis: 1'b0,
                                   fs: 1'b0, use_fb: 1'b0, pat: 8'h00};

  // MSB-first bit replication of a grey pixel to 3 bits.
  function automatic logic [2:0] expand3(input logic [DIN_W-1:0] d);
    logic [2:0] res;
    res = 3'b000;
    for (int i = 0; i < 3; i++) res[2-i] = d[DIN_W-1-(i % DIN_W)];
    return res;
  endfunction

  // MSB-first bit replication of a grey pixel to 2 bits.
  function automatic logic [1:0] expand2(input logic [DIN_W-1:0] d);
    logic [1:0] res;
    res = 2'b00;
    for (int i = 0; i < 2; i++) res[1-i] = d[DIN_W-1-(i % DIN_W)];
    return res;
  endfunction

  logic [HC_W-1:0]   hcnt_r, hcnt_nxt_s;
  logic [VC_W-1:0]   vcnt_r, vcnt_nxt_s;
  logic [XS_W-1:0]   x_sub_r, x_sub_nxt_s, y_sub_r, y_sub_nxt_s;
  logic [ADDR_W-1:0] fb_x_r, fb_x_nxt_s, line_base_r, line_base_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic              h_wrap_s, v_wrap_s, h_vis_s, v_vis_s, vis_nxt_s;
  logic              frame_first_s, chk_s;
  logic [1:0]        mode_r, mode_s;
  logic [7:0]        solid_r, solid_s, px_s;
  logic [2:0]        bar_s;
  stage_t            stg_s, last_s;
  stage_t            dl_r [RAM_LAT];

  assign fb.addr = addr_r;

  // Next counter position and the incremental framebuffer address for it, so
  // addr_r always belongs to the pixel the counters currently point at.
  always_comb begin
    h_wrap_s   = (32'(hcnt_r) == H_TOTAL - 1);
    v_wrap_s   = (32'(vcnt_r) == V_TOTAL - 1);
    h_vis_s    = (32'(hcnt_r) < H_ACTIVE);
    v_vis_s    = (32'(vcnt_r) < V_ACTIVE);
    hcnt_nxt_s = h_wrap_s ? '0 : hcnt_r + 1'b1;
    if (h_wrap_s) begin
      vcnt_nxt_s = v_wrap_s ? '0 : vcnt_r + 1'b1;
    end else begin
      vcnt_nxt_s = vcnt_r;
    end

    x_sub_nxt_s = x_sub_r;
    fb_x_nxt_s  = fb_x_r;
    if (h_wrap_s) begin
      x_sub_nxt_s = '0;
      fb_x_nxt_s  = '0;
    end else if (h_vis_s) begin
      if (x_sub_r == XS_LAST) begin
        x_sub_nxt_s = '0;
        fb_x_nxt_s  = fb_x_r + 1'b1;
      end else begin
        x_sub_nxt_s = x_sub_r + 1'b1;
        fb_x_nxt_s  = fb_x_r;
      end
    end else begin
      x_sub_nxt_s = x_sub_r;
      fb_x_nxt_s  = fb_x_r;
    end

    // line_base moves on only after the last replica of a framebuffer row.
    y_sub_nxt_s     = y_sub_r;
    line_base_nxt_s = line_base_r;
    if (h_wrap_s && v_wrap_s) begin
      y_sub_nxt_s     = '0;
      line_base_nxt_s = '0;
    end else if (h_wrap_s && v_vis_s) begin
      if (y_sub_r == XS_LAST) begin
        y_sub_nxt_s     = '0;
        line_base_nxt_s = line_base_r + FB_STEP;
      end else begin
        y_sub_nxt_s     = y_sub_r + 1'b1;
        line_base_nxt_s = line_base_r;
      end
    end else begin
      y_sub_nxt_s     = y_sub_r;
      line_base_nxt_s = line_base_r;
    end

    vis_nxt_s  = (32'(hcnt_nxt_s) < H_ACTIVE) && (32'(vcnt_nxt_s) < V_ACTIVE);
    addr_nxt_s = vis_nxt_s ? (line_base_nxt_s + fb_x_nxt_s) : '0;
  end

  // Timing counters, address generator and the registered RAM address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r      <= '0;
      vcnt_r      <= '0;
      x_sub_r     <= '0;
      y_sub_r     <= '0;
      fb_x_r      <= '0;
      line_base_r <= '0;
      addr_r      <= '0;
    end else begin
      hcnt_r      <= hcnt_nxt_s;
      vcnt_r      <= vcnt_nxt_s;
      x_sub_r     <= x_sub_nxt_s;
      y_sub_r     <= y_sub_nxt_s;
      fb_x_r      <= fb_x_nxt_s;
      line_base_r <= line_base_nxt_s;
      addr_r      <= addr_nxt_s;
    end
  end

  // Counter-stage syncs and pattern; mode/solid are taken live at (0,0) so the
  // first pixel of a frame already uses the newly sampled settings.
  always_comb begin
    frame_first_s = (hcnt_r == '0) && (vcnt_r == '0);
    mode_s        = frame_first_s ? mode : mode_r;
    solid_s       = frame_first_s ? solid_rgb : solid_r;
    bar_s         = 3'(32'(hcnt_r) / BAR_W);
    chk_s         = ((32'(hcnt_r) ^ 32'(vcnt_r)) & 32'h0000_0020) != 32'h0000_0000;
    stg_s         = STAGE_RST;
    stg_s.hs  = ((32'(hcnt_r) >= H_ACTIVE + H_FP) &&
                 (32'(hcnt_r) <  H_ACTIVE + H_FP + H_SYNC)) ? SYNC_ON : SYNC_OFF;
    stg_s.vs  = ((32'(vcnt_r) >= V_ACTIVE + V_FP) &&
                 (32'(vcnt_r) <  V_ACTIVE + V_FP + V_SYNC)) ? SYNC_ON : SYNC_OFF;
    stg_s.vis = h_vis_s && v_vis_s;
    stg_s.fs  = frame_first_s;
    case (mode_s)
      2'd0:    begin stg_s.use_fb = 1'b1; stg_s.pat = 8'h00; end
      2'd1:    stg_s.pat = {{3{bar_s[2]}}, {3{bar_s[1]}}, {2{bar_s[0]}}};
      2'd2:    stg_s.pat = chk_s ? 8'hFF : 8'h00;
      2'd3:    stg_s.pat = solid_s;
      default: stg_s.pat = 8'h00;
    endcase
  end

  // Frame-wide mode/solid registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_r  <= 2'd0;
      solid_r <= 8'h00;
    end else begin
      mode_r  <= mode_s;
      solid_r <= solid_s;
    end
  end

  // RAM_LAT-deep delay line so control bits meet din at the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RAM_LAT; i++) dl_r[i] <= STAGE_RST;
    end else begin
      dl_r[0] <= stg_s;
      for (int i = 1; i < RAM_LAT; i++) dl_r[i] <= dl_r[i-1];
    end
  end

  // Final pixel select with blanking.
  always_comb begin
    last_s = dl_r[RAM_LAT-1];
    if (!last_s.vis) begin
      px_s = 8'h00;
    end else if (last_s.use_fb) begin
      px_s = {expand3(fb.din), expand3(fb.din), expand2(fb.din)};
    end else begin
      px_s = last_s.pat;
    end
  end

  // Output register stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      active      <= 1'b0;
      frame_start <= 1'b0;
      {R, G, B}   <= 8'h00;
    end else begin
      hsync       <= last_s.hs;
      vsync       <= last_s.vs;
      active      <= last_s.vis;
      frame_start <= last_s.fs;
      {R, G, B}   <= px_s;
    end
  end

endmodule
